// File: rtl/timer_pkg.sv
// Shared constants and state type for the hour/min/sec clock family.
// Mixed radix: sec 0..19, min 0..9, hour 0..4.
package timer_pkg;

  localparam int HOUR_W = 3;
  localparam int MIN_W  = 4;
  localparam int SEC_W  = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 5'd19;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 4'd9;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } timer_state_e;

endpackage

// File: rtl/td_digit_dec.sv
// Single-field decrementer. Three of these chained sec->min->hour form the
// borrow chain of countdown_timer.
module td_digit_dec #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_value,
  input  logic [W-1:0] i_max,
  input  logic         i_borrow_in,
  output logic [W-1:0] o_next,
  output logic         o_borrow_out
);

  logic w_zero;

  assign w_zero       = (i_value == '0);
  assign o_borrow_out = w_zero & i_borrow_in;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    o_next = i_value;
    if (i_borrow_in) begin
      o_next = w_zero ? i_max : (i_value - W'(1));
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable hour/min/sec down-counter with start/pause and a one-cycle done pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload from the last accepted load on expiry.
module countdown_timer
  import timer_pkg::*;
#(
  parameter logic [SEC_W-1:0]  SEC_MAX  = timer_pkg::SEC_MAX,
  parameter logic [MIN_W-1:0]  MIN_MAX  = timer_pkg::MIN_MAX,
  parameter logic [HOUR_W-1:0] HOUR_MAX = timer_pkg::HOUR_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_load,
  input  logic [HOUR_W-1:0] i_load_hour,
  input  logic [MIN_W-1:0]  i_load_min,
  input  logic [SEC_W-1:0]  i_load_sec,
  input  logic              i_start,
  input  logic              i_pause,
  output logic [HOUR_W-1:0] o_hour,
  output logic [MIN_W-1:0]  o_min,
  output logic [SEC_W-1:0]  o_sec,
  output logic              o_running,
  output logic              o_done,
  output logic              o_load_err
);

  timer_state_e      r_state, w_state_nxt;
  logic [HOUR_W-1:0] r_hour, w_hour_nxt;
  logic [MIN_W-1:0]  r_min, w_min_nxt;
  logic [SEC_W-1:0]  r_sec, w_sec_nxt;
  logic              r_running, r_done, r_load_err;
  logic              w_done_nxt, w_load_err_nxt;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [HOUR_W-1:0] r_sh_hour, w_sh_hour_nxt;
  logic [MIN_W-1:0]  r_sh_min, w_sh_min_nxt;
  logic [SEC_W-1:0]  r_sh_sec, w_sh_sec_nxt;
  logic              w_sh_zero;
`endif

  logic [HOUR_W-1:0] w_dec_hour;
  logic [MIN_W-1:0]  w_dec_min;
  logic [SEC_W-1:0]  w_dec_sec;
  logic              w_sec_borrow, w_min_borrow, w_hour_borrow;
  logic              w_load_ok, w_cnt_zero, w_dec_zero;

  td_digit_dec #(.W(SEC_W)) u_sec_dec (
    .i_value      (r_sec),
    .i_max        (SEC_MAX),
    .i_borrow_in  (1'b1),
    .o_next       (w_dec_sec),
    .o_borrow_out (w_sec_borrow)
  );

  td_digit_dec #(.W(MIN_W)) u_min_dec (
    .i_value      (r_min),
    .i_max        (MIN_MAX),
    .i_borrow_in  (w_sec_borrow),
    .o_next       (w_dec_min),
    .o_borrow_out (w_min_borrow)
  );

  td_digit_dec #(.W(HOUR_W)) u_hour_dec (
    .i_value      (r_hour),
    .i_max        (HOUR_MAX),
    .i_borrow_in  (w_min_borrow),
    .o_next       (w_dec_hour),
    .o_borrow_out (w_hour_borrow)
  );

  assign w_load_ok  = (i_load_hour <= HOUR_MAX) && (i_load_min <= MIN_MAX) &&
                      (i_load_sec <= SEC_MAX);
  assign w_cnt_zero = (r_hour == '0) && (r_min == '0) && (r_sec == '0);
  // An hour borrow would be an underflow; treat it as terminal rather than wrap.
  assign w_dec_zero = ((w_dec_hour == '0) && (w_dec_min == '0) && (w_dec_sec == '0)) ||
                      w_hour_borrow;

`ifdef COUNTDOWN_AUTORELOAD_EN
  assign w_sh_zero = (r_sh_hour == '0) && (r_sh_min == '0) && (r_sh_sec == '0);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_hour_nxt     = r_hour;
    w_min_nxt      = r_min;
    w_sec_nxt      = r_sec;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    w_sh_hour_nxt  = r_sh_hour;
    w_sh_min_nxt   = r_sh_min;
    w_sh_sec_nxt   = r_sh_sec;
`endif

    if (i_load) begin
      if (w_load_ok) begin
        w_hour_nxt    = i_load_hour;
        w_min_nxt     = i_load_min;
        w_sec_nxt     = i_load_sec;
        w_state_nxt   = S_IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
        w_sh_hour_nxt = i_load_hour;
        w_sh_min_nxt  = i_load_min;
        w_sh_sec_nxt  = i_load_sec;
`endif
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if (i_start) begin
            if (w_cnt_zero) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (i_pause) begin
            w_state_nxt = S_PAUSE;
          end else if (i_tick) begin
            w_hour_nxt = w_dec_hour;
            w_min_nxt  = w_dec_min;
            w_sec_nxt  = w_dec_sec;
            if (w_dec_zero) begin
              w_done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (w_sh_zero) begin
                w_state_nxt = S_DONE;
              end else begin
                w_hour_nxt = r_sh_hour;
                w_min_nxt  = r_sh_min;
                w_sec_nxt  = r_sh_sec;
              end
`else
              w_state_nxt = S_DONE;
`endif
            end
          end
        end
        S_DONE:  ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      r_sh_hour  <= '0;
      r_sh_min   <= '0;
      r_sh_sec   <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_hour     <= w_hour_nxt;
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_done     <= w_done_nxt;
      r_load_err <= w_load_err_nxt;
`ifdef COUNTDOWN_AUTORELOAD_EN
      r_sh_hour  <= w_sh_hour_nxt;
      r_sh_min   <= w_sh_min_nxt;
      r_sh_sec   <= w_sh_sec_nxt;
`endif
    end
  end

  assign o_hour     = r_hour;
  assign o_min      = r_min;
  assign o_sec      = r_sec;
  assign o_running  = r_running;
  assign o_done     = r_done;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: the driver pushes the expected output
// bundle for every clock it drives; a monitor pops and compares after each edge.
module tb_countdown_timer;

  typedef struct packed {
    logic [2:0] h;
    logic [3:0] m;
    logic [4:0] s;
    logic       run;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_tick = 1'b0, i_load = 1'b0, i_start = 1'b0, i_pause = 1'b0;
  logic [2:0] i_load_hour = '0;
  logic [3:0] i_load_min  = '0;
  logic [4:0] i_load_sec  = '0;
  logic [2:0] o_hour;
  logic [3:0] o_min;
  logic [4:0] o_sec;
  logic       o_running, o_done, o_load_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  countdown_timer dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_load      (i_load),
    .i_load_hour (i_load_hour),
    .i_load_min  (i_load_min),
    .i_load_sec  (i_load_sec),
    .i_start     (i_start),
    .i_pause     (i_pause),
    .o_hour      (o_hour),
    .o_min       (o_min),
    .o_sec       (o_sec),
    .o_running   (o_running),
    .o_done      (o_done),
    .o_load_err  (o_load_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(input int h, input int m, input int s,
                             input logic run, input logic done, input logic err);
    exp_t e;
    e.h = 3'(h); e.m = 4'(m); e.s = 5'(s);
    e.run = run; e.done = done; e.err = err;
    return e;
  endfunction

  // Expected count from a total number of seconds (200 s per hour, 20 s per minute).
  function automatic exp_t from_total(input int total, input logic run, input logic done);
    return E(total / 200, (total % 200) / 20, total % 20, run, done, 1'b0);
  endfunction

  // Monitor: one comparison per driven clock, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t got, e;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {o_hour, o_min, o_sec, o_running, o_done, o_load_err};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got %0d:%0d:%0d run=%0b done=%0b err=%0b, expected %0d:%0d:%0d run=%0b done=%0b err=%0b",
                 $time, got.h, got.m, got.s, got.run, got.done, got.err,
                 e.h, e.m, e.s, e.run, e.done, e.err);
      end
    end
  end

  task automatic step(input logic t, input logic ld, input int h, input int m, input int s,
                      input logic st, input logic ps, input exp_t e);
    @(negedge clk);
    i_tick      = t;
    i_load      = ld;
    i_load_hour = 3'(h);
    i_load_min  = 4'(m);
    i_load_sec  = 5'(s);
    i_start     = st;
    i_pause     = ps;
    exp_q.push_back(e);
  endtask

  task automatic idle(input exp_t e);   step(0, 0, 0, 0, 0, 0, 0, e); endtask
  task automatic tick(input exp_t e);   step(1, 0, 0, 0, 0, 0, 0, e); endtask
  task automatic start(input exp_t e);  step(0, 0, 0, 0, 0, 1, 0, e); endtask
  task automatic load(input int h, input int m, input int s, input exp_t e);
    step(0, 1, h, m, s, 0, 0, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(E(0, 0, 0, 0, 0, 0));
    idle(E(0, 0, 0, 0, 0, 0));
    rst = 1'b0;

`ifdef COUNTDOWN_AUTORELOAD_EN
    // Autoreload: 0:0:2 expires every second tick, stays running
    load(0, 0, 2, E(0, 0, 2, 0, 0, 0));
    start(E(0, 0, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick(E(0, 0, 1, 1, 0, 0));
      tick(E(0, 0, 2, 1, 1, 0));
    end
    step(0, 0, 0, 0, 0, 0, 1, E(0, 0, 2, 0, 0, 0));
`else
    // 0:0:3 runs out: single done pulse, holds in DONE
    load(0, 0, 3, E(0, 0, 3, 0, 0, 0));
    start(E(0, 0, 3, 1, 0, 0));
    tick(E(0, 0, 2, 1, 0, 0));
    tick(E(0, 0, 1, 1, 0, 0));
    tick(E(0, 0, 0, 0, 1, 0));
    tick(E(0, 0, 0, 0, 0, 0));
    start(E(0, 0, 0, 0, 0, 0));

    // 1:0:0 full borrow chain down to zero
    load(1, 0, 0, E(1, 0, 0, 0, 0, 0));
    start(E(1, 0, 0, 1, 0, 0));
    tick(E(0, 9, 19, 1, 0, 0));
    for (int k = 2; k <= 199; k++) tick(from_total(200 - k, 1'b1, 1'b0));
    tick(E(0, 0, 0, 0, 1, 0));
    idle(E(0, 0, 0, 0, 0, 0));
`endif

    // Rejected loads leave the count alone; boundary load accepted
    load(5, 0, 0, E(0, 0, 0, 0, 0, 1));
    load(0, 10, 0, E(0, 0, 0, 0, 0, 1));
    load(0, 0, 20, E(0, 0, 0, 0, 0, 1));
    idle(E(0, 0, 0, 0, 0, 0));
    load(4, 9, 19, E(4, 9, 19, 0, 0, 0));

    // Pause/resume and start/pause collisions
    load(0, 0, 10, E(0, 0, 10, 0, 0, 0));
    start(E(0, 0, 10, 1, 0, 0));
    tick(E(0, 0, 9, 1, 0, 0));
    tick(E(0, 0, 8, 1, 0, 0));
    tick(E(0, 0, 7, 1, 0, 0));
    step(1, 0, 0, 0, 0, 0, 1, E(0, 0, 7, 0, 0, 0));
    tick(E(0, 0, 7, 0, 0, 0));
    tick(E(0, 0, 7, 0, 0, 0));
    step(1, 0, 0, 0, 0, 1, 1, E(0, 0, 7, 1, 0, 0));
    tick(E(0, 0, 6, 1, 0, 0));
    step(1, 0, 0, 0, 0, 1, 1, E(0, 0, 6, 0, 0, 0));
    step(1, 0, 0, 0, 0, 1, 0, E(0, 0, 6, 1, 0, 0));
    tick(E(0, 0, 5, 1, 0, 0));

    // Load beats a tick on the terminal step: no done
    step(1, 1, 0, 0, 1, 0, 0, E(0, 0, 1, 0, 0, 0));
    start(E(0, 0, 1, 1, 0, 0));
    step(1, 1, 0, 0, 2, 0, 0, E(0, 0, 2, 0, 0, 0));

    // Zero count start: immediate done, no tick needed
    load(0, 0, 0, E(0, 0, 0, 0, 0, 0));
    start(E(0, 0, 0, 0, 1, 0));
    idle(E(0, 0, 0, 0, 0, 0));

    // Reset mid-run clears count and the reload value
    load(2, 3, 4, E(2, 3, 4, 0, 0, 0));
    start(E(2, 3, 4, 1, 0, 0));
    tick(E(2, 3, 3, 1, 0, 0));
    tick(E(2, 3, 2, 1, 0, 0));
    @(negedge clk);
    i_tick = 1'b0;
    rst    = 1'b1;
    exp_q.push_back(E(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(E(0, 0, 0, 0, 0, 0));
    tick(E(0, 0, 0, 0, 0, 0));
    start(E(0, 0, 0, 0, 1, 0));
    idle(E(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
